// File: rtl/muxn_pkg.sv
// ---------------------------------------------------------------------------
// muxn_pkg
// Shared constants and elaboration helpers for the muxn_scan channel
// multiplexer/scanner.
//   MODE_MANUAL / MODE_AUTO : encodings of the mode input
//   clog2()                 : ceiling log2, used for parameter checks and
//                             counter sizing
// ---------------------------------------------------------------------------
package muxn_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   // Ceiling log2 of a positive value; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 32'sd1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/muxn_scan_if.sv
// ---------------------------------------------------------------------------
// muxn_scan_if
// Channel bank / select / status bundle of muxn_scan.
//   in        : N*W  channel k at in[k*W +: W]
//   mode      : 0 manual, 1 auto-scan
//   sel       : manual channel select
//   en        : pointer and dwell counter may update
//   out       : registered selected channel data
//   cur_sel   : registered channel pointer
//   out_valid : out holds real channel data
//   wrap      : one-cycle pulse on auto pointer wrap N-1 -> 0
//   sel_err   : one-cycle flag for a manual select >= N
// master drives the inputs of the block, slave is the multiplexer itself.
// ---------------------------------------------------------------------------
interface muxn_scan_if #(
   parameter int N    = 8,
   parameter int W    = 1,
   parameter int SELW = 3
);

   logic [N*W-1:0]  in;
   logic            mode;
   logic [SELW-1:0] sel;
   logic            en;
   logic [W-1:0]    out;
   logic [SELW-1:0] cur_sel;
   logic            out_valid;
   logic            wrap;
   logic            sel_err;

   modport master (
      output in, mode, sel, en,
      input  out, cur_sel, out_valid, wrap, sel_err
   );

   modport slave (
      input  in, mode, sel, en,
      output out, cur_sel, out_valid, wrap, sel_err
   );

endinterface

// File: rtl/muxn_dwell_ctr.sv
// ---------------------------------------------------------------------------
// muxn_dwell_ctr
// Dwell counter for the auto-scan pointer. Counts 0..DWELL-1 while enabled,
// restarting at 0 after the terminal count; clr forces it back to 0 and
// takes priority over en.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear
//   en       : count enable (counter frozen when low)
//   tc       : counter is at DWELL-1 (pointer advances on this edge)
// ---------------------------------------------------------------------------
module muxn_dwell_ctr
   import muxn_pkg::*;
#(
   parameter int DWELL = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   // A single-cycle dwell still needs a 1-bit register to stay legal.
   localparam int CW = (DWELL > 1) ? clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

   logic [CW-1:0] cnt_r;

   assign tc = (cnt_r == LAST_CNT);

   // Dwell count register: clear, count with roll-over at terminal, or hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en) begin
         if (tc) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + 1'b1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/muxn_scan.sv
// ---------------------------------------------------------------------------
// muxn_scan
// N:1 multiplexer of W-bit channels with a registered output and a channel
// pointer that is either loaded from sel (manual) or stepped through all
// channels every DWELL cycles (auto-scan).
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : muxn_scan_if slave port (in/mode/sel/en in, out/cur_sel/
//         out_valid/wrap/sel_err out, all outputs registered)
// ---------------------------------------------------------------------------
module muxn_scan
   import muxn_pkg::*;
#(
   parameter int N     = 8,
   parameter int W     = 1,
   parameter int SELW  = 3,
   parameter int DWELL = 1
) (
   input  logic       clk,
   input  logic       rst,
   muxn_scan_if.slave bus
);

   localparam int NSLOT = 1 << SELW;
   // One extra bit so the range check works when N == 2**SELW.
   localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N);
   localparam logic [SELW-1:0] LAST_SEL = SELW'(N - 1);

   if (clog2(N) > SELW || N < 2 || DWELL < 1) begin : g_param_check
      $error("muxn_scan: illegal parameters N=%0d SELW=%0d DWELL=%0d",
             N, SELW, DWELL);
   end

   logic [W-1:0]    chan_s [NSLOT];
   logic            sel_ok_s;
   logic [SELW-1:0] ptr_nxt_s;
   logic            wrap_nxt_s;
   logic            err_nxt_s;
   logic            ctr_clr_s;
   logic            ctr_en_s;
   logic            tc_s;

   logic [W-1:0]    out_r;
   logic [SELW-1:0] cur_sel_r;
   logic            out_valid_r;
   logic            wrap_r;
   logic            sel_err_r;

   // Channel table padded to the full select range so any pointer value
   // indexes a defined entry; unused slots read as zero.
   for (genvar k = 0; k < NSLOT; k++) begin : g_chan
      if (k < N) begin : g_live
         assign chan_s[k] = bus.in[k*W +: W];
      end else begin : g_pad
         assign chan_s[k] = '0;
      end
   end

   assign sel_ok_s = ({1'b0, bus.sel} < N_EXT);

   muxn_dwell_ctr #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (ctr_clr_s),
      .en  (ctr_en_s),
      .tc  (tc_s)
   );

   // Next pointer, flags and dwell-counter control from mode/en/sel.
   always_comb begin
      ptr_nxt_s  = cur_sel_r;
      wrap_nxt_s = 1'b0;
      err_nxt_s  = 1'b0;
      ctr_clr_s  = 1'b0;
      ctr_en_s   = 1'b0;
      if (bus.en) begin
         if (bus.mode == MODE_AUTO) begin
            ctr_en_s = 1'b1;
            if (tc_s) begin
               if (cur_sel_r == LAST_SEL) begin
                  ptr_nxt_s  = '0;
                  wrap_nxt_s = 1'b1;
               end else begin
                  ptr_nxt_s  = cur_sel_r + 1'b1;
                  wrap_nxt_s = 1'b0;
               end
            end else begin
               ptr_nxt_s  = cur_sel_r;
               wrap_nxt_s = 1'b0;
            end
         end else begin
            // Manual: dwell restarts from 0 whenever auto mode resumes.
            ctr_clr_s = 1'b1;
            if (sel_ok_s) begin
               ptr_nxt_s = bus.sel;
               err_nxt_s = 1'b0;
            end else begin
               ptr_nxt_s = cur_sel_r;
               err_nxt_s = 1'b1;
            end
         end
      end else begin
         ptr_nxt_s  = cur_sel_r;
         wrap_nxt_s = 1'b0;
         err_nxt_s  = 1'b0;
      end
   end

   // Pointer, output data and status registers. The cycle after a select
   // error the output is forced to zero instead of the held channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_r       <= '0;
         cur_sel_r   <= '0;
         out_valid_r <= 1'b0;
         wrap_r      <= 1'b0;
         sel_err_r   <= 1'b0;
      end else begin
         if (sel_err_r) begin
            out_r <= '0;
         end else begin
            out_r <= chan_s[cur_sel_r];
         end
         out_valid_r <= 1'b1;
         cur_sel_r   <= ptr_nxt_s;
         wrap_r      <= wrap_nxt_s;
         sel_err_r   <= err_nxt_s;
      end
   end

   assign bus.out       = out_r;
   assign bus.cur_sel   = cur_sel_r;
   assign bus.out_valid = out_valid_r;
   assign bus.wrap      = wrap_r;
   assign bus.sel_err   = sel_err_r;

endmodule

// File: tb/tb_muxn_scan.sv
// ---------------------------------------------------------------------------
// tb_muxn_scan
// Two muxn_scan instances share one stimulus stream:
//   dut_a : N=8, W=1, SELW=3, DWELL=1
//   dut_b : N=6, W=4, SELW=3, DWELL=3
// Inputs change on the falling edge; a reference model predicts the outputs
// after the next rising edge and queues them; a monitor pops and compares
// 1 ns after each rising edge (or after a mid-cycle asynchronous reset).
// ---------------------------------------------------------------------------
module tb_muxn_scan;

   typedef struct packed {
      logic [3:0] out;
      logic [2:0] cs;
      logic       v;
      logic       w;
      logic       e;
   } exp_t;

   localparam int CN [2] = '{8, 6};
   localparam int CWD[2] = '{1, 4};
   localparam int CD [2] = '{1, 3};

   logic        clk;
   logic        rst;
   logic [23:0] in_s;
   logic        mode_s;
   logic [2:0]  sel_s;
   logic        en_s;

   muxn_scan_if #(.N(8), .W(1), .SELW(3)) bus_a ();
   muxn_scan_if #(.N(6), .W(4), .SELW(3)) bus_b ();

   assign bus_a.in   = in_s[7:0];
   assign bus_a.mode = mode_s;
   assign bus_a.sel  = sel_s;
   assign bus_a.en   = en_s;
   assign bus_b.in   = in_s;
   assign bus_b.mode = mode_s;
   assign bus_b.sel  = sel_s;
   assign bus_b.en   = en_s;

   muxn_scan #(.N(8), .W(1), .SELW(3), .DWELL(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   muxn_scan #(.N(6), .W(4), .SELW(3), .DWELL(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state per instance: pointer, cycles spent on the
   // current channel, and the expected visible outputs.
   int   mp  [2];
   int   mdw [2];
   int   mout[2];
   bit   mv  [2];
   bit   mw  [2];
   bit   me  [2];

   exp_t qa[$];
   exp_t qb[$];
   int   npush = 0;
   int   npop  = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   event chk_ev;

   function automatic void chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
      end
   endfunction

   // Advance the model of instance c by one rising edge with current inputs
   // (or apply reset) and queue the expected outputs.
   function automatic void model_step(input int c);
      int   n, w, d;
      exp_t e;
      n = CN[c];
      w = CWD[c];
      d = CD[c];
      if (rst) begin
         mp[c] = 0; mdw[c] = 0; mout[c] = 0; mv[c] = 0; mw[c] = 0; me[c] = 0;
      end else begin
         mout[c] = me[c] ? 0 : ((int'(in_s) >> (mp[c] * w)) & ((1 << w) - 1));
         mv[c] = 1;
         if (!en_s) begin
            mw[c] = 0;
            me[c] = 0;
         end else if (mode_s == 1'b0) begin
            mw[c]  = 0;
            mdw[c] = 0;
            if (int'(sel_s) < n) begin
               mp[c] = int'(sel_s);
               me[c] = 0;
            end else begin
               me[c] = 1;
            end
         end else begin
            me[c] = 0;
            mdw[c]++;
            if (mdw[c] == d) begin
               mdw[c] = 0;
               mw[c]  = (mp[c] == n - 1);
               mp[c]  = (mp[c] + 1) % n;
            end else begin
               mw[c] = 0;
            end
         end
      end
      e.out = 4'(mout[c]);
      e.cs  = 3'(mp[c]);
      e.v   = mv[c];
      e.w   = mw[c];
      e.e   = me[c];
      if (c == 0) qa.push_back(e);
      else        qb.push_back(e);
      npush++;
   endfunction

   task automatic cycle(input logic r, input logic [23:0] i, input logic m,
                        input logic [2:0] s, input logic e);
      @(negedge clk);
      rst = r; in_s = i; mode_s = m; sel_s = s; en_s = e;
      model_step(0);
      model_step(1);
   endtask

   // Monitor: compare DUT outputs with the oldest queued expectation.
   initial begin
      exp_t ea, eb;
      forever begin
         @(posedge clk or chk_ev);
         #1;
         if (qa.size() > 0) begin
            ea = qa.pop_front();
            npop++;
            chk("a.out",       int'(bus_a.out),       int'(ea.out));
            chk("a.cur_sel",   int'(bus_a.cur_sel),   int'(ea.cs));
            chk("a.out_valid", int'(bus_a.out_valid), int'(ea.v));
            chk("a.wrap",      int'(bus_a.wrap),      int'(ea.w));
            chk("a.sel_err",   int'(bus_a.sel_err),   int'(ea.e));
         end
         if (qb.size() > 0) begin
            eb = qb.pop_front();
            npop++;
            chk("b.out",       int'(bus_b.out),       int'(eb.out));
            chk("b.cur_sel",   int'(bus_b.cur_sel),   int'(eb.cs));
            chk("b.out_valid", int'(bus_b.out_valid), int'(eb.v));
            chk("b.wrap",      int'(bus_b.wrap),      int'(eb.w));
            chk("b.sel_err",   int'(bus_b.sel_err),   int'(eb.e));
         end
      end
   end

   // Watchdog: the stimulus is bounded, this only guards against a hang.
   initial begin
      #500000;
      $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
      $fatal(1);
   end

   localparam logic [23:0] PAT = 24'h555555;

   initial begin
      logic m;
      rst = 1'b1; in_s = 24'hFFFFFF; mode_s = 1'b1; sel_s = 3'd0; en_s = 1'b1;
      for (int c = 0; c < 2; c++) begin
         mp[c] = 0; mdw[c] = 0; mout[c] = 0; mv[c] = 0; mw[c] = 0; me[c] = 0;
      end

      // Reset held with all-ones inputs in auto mode.
      for (int k = 0; k < 3; k++) cycle(1'b1, 24'hFFFFFF, 1'b1, 3'd0, 1'b1);

      // Manual selects on the alternating pattern.
      for (int k = 0; k < 2; k++) cycle(1'b0, PAT, 1'b0, 3'd3, 1'b1);
      for (int k = 0; k < 2; k++) cycle(1'b0, PAT, 1'b0, 3'd4, 1'b1);

      // Auto scan from pointer 4 through several wraps of both instances.
      for (int k = 0; k < 40; k++) cycle(1'b0, PAT, 1'b1, 3'd0, 1'b1);

      // Out-of-range manual selects (7 bad for both widths of N? only N=6).
      cycle(1'b0, 24'($urandom), 1'b0, 3'd2, 1'b1);
      cycle(1'b0, 24'($urandom), 1'b0, 3'd7, 1'b1);
      cycle(1'b0, 24'($urandom), 1'b0, 3'd6, 1'b1);
      for (int k = 0; k < 3; k++) cycle(1'b0, 24'($urandom), 1'b0, 3'd1, 1'b1);

      // Freeze in auto at pointer 2, live data keeps flowing, then resume.
      cycle(1'b0, 24'($urandom), 1'b0, 3'd2, 1'b1);
      for (int k = 0; k < 4; k++) cycle(1'b0, 24'($urandom), 1'b1, 3'd5, 1'b0);
      for (int k = 0; k < 8; k++) cycle(1'b0, 24'($urandom), 1'b1, 3'd5, 1'b1);

      // Mode change while frozen, then enable.
      cycle(1'b0, 24'($urandom), 1'b0, 3'd5, 1'b0);
      cycle(1'b0, 24'($urandom), 1'b0, 3'd5, 1'b1);
      cycle(1'b0, 24'($urandom), 1'b1, 3'd0, 1'b0);
      for (int k = 0; k < 4; k++) cycle(1'b0, 24'($urandom), 1'b1, 3'd0, 1'b1);

      // Asynchronous reset in the middle of a clock period during a scan.
      @(posedge clk);
      #3;
      rst = 1'b1;
      model_step(0);
      model_step(1);
      -> chk_ev;
      for (int k = 0; k < 2; k++) cycle(1'b1, 24'($urandom), 1'b1, 3'd0, 1'b1);
      for (int k = 0; k < 10; k++) cycle(1'b0, 24'($urandom), 1'b1, 3'd0, 1'b1);

      // Randomised traffic with occasional mode flips, freezes and resets.
      m = 1'b1;
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 7) == 0) m = ~m;
         cycle(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
               24'($urandom), m,
               3'($urandom_range(0, 7)),
               ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0);
      end

      // Drain the scoreboard and confirm every expectation was consumed.
      @(posedge clk);
      #2;
      chk("drain", npop, npush);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/muxn_scan.md
# muxn_scan

Parametrised N:1 multiplexer with registered output and a built-in channel scanner. It generalises the fixed 8:1 single-bit mux to N channels of W bits each. It offers two modes: manual, where the select comes from a port, and auto-scan, where an internal pointer steps through all channels with a programmable dwell. It sits between a bank of sampled input channels and a single serial consumer, such as a monitor or a time-division output.

## Interface
Parameters:
- N, 8, number of input channels (≥2)
- W, 1, width of each channel in bits
- SELW, 3, select width; must satisfy 2**SELW ≥ N
- DWELL, 1, cycles spent on each channel in auto mode (≥1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in  input  N*W  channel k occupies in[k*W +: W]
- mode  input  1  0 = manual, 1 = auto-scan
- sel  input  SELW  manual channel select
- en  input  1  1 = pointer may update; 0 = pointer and dwell counter frozen
- out  output  W  registered selected channel data
- cur_sel  output  SELW  registered channel pointer
- out_valid  output  1  out holds real channel data
- wrap  output  1  one-cycle pulse when the auto pointer wraps N-1 → 0
- sel_err  output  1  one-cycle flag: manual sel ≥ N

## Operation
- Reset (async assert): out=0, cur_sel=0, out_valid=0, wrap=0, sel_err=0, dwell counter=0.
- out path, every edge regardless of en: out <= in[cur_sel*W +: W]. out_valid <= 1 from the first edge after rst deasserts.
- Manual (mode=0, en=1):
  - sel < N: cur_sel <= sel, sel_err <= 0.
  - sel ≥ N: cur_sel holds, sel_err <= 1. The next out is forced to 0 for that one cycle.
  - The dwell counter is held at 0.
- Auto (mode=1, en=1):
  - The dwell counter counts 0..DWELL-1.
  - At DWELL-1 the counter returns to 0 and cur_sel advances by 1.
  - At N-1 the pointer goes to 0 instead, and wrap <= 1 for one cycle.
  - sel is ignored; sel_err=0.
- en=0: cur_sel, dwell counter, wrap=0 and sel_err=0 are frozen or deasserted; out keeps sampling the frozen channel.
- Mode change:
  - Manual→auto: scanning resumes from the current cur_sel with the dwell counter at 0.
  - Auto→manual: sel is loaded on the same edge mode is seen low.
- Reset mid-scan: all state returns to its reset value immediately (async). The scan restarts at channel 0 after release.

## Timing
- Manual latency: sel at edge t → cur_sel valid after t → out valid after edge t+1 (two cycles sel→out).
- Auto: cur_sel changes every DWELL cycles. out follows cur_sel one cycle later.
- wrap is asserted in the same cycle cur_sel shows 0 after N-1.
- sel_err is asserted in the cycle after the offending sel was sampled. The forced-zero out follows one cycle after that.
- Simultaneous en=0 and a mode change: the mode is registered, but the pointer does not move until en=1.

## Structure
- Package muxn_pkg holds:
  - MODE_MANUAL=1'b0 and MODE_AUTO=1'b1 constants.
  - A clog2 function used for parameter checks.
- Sub-module muxn_dwell_ctr contains the dwell counter with clear/enable and a terminal-count output. It drives the pointer advance in the top.
- The top holds the pointer register, range check, output register and flags.
- An elaboration-time check fails if 2**SELW < N or DWELL < 1.

## Test plan
- Reset: assert rst with in=8'hFF, mode=1 → out=0, cur_sel=0, out_valid=0, wrap=0, sel_err=0. out_valid=1 one edge after release.
- Manual, N=8, W=1, in=8'b01010101:
  - sel=3'b011 → cur_sel=3 after 1 edge, out=0 after 2.
  - sel=3'b100 → out=1 two edges later.
- Auto, DWELL=1, in=8'b01010101:
  - cur_sel steps 0,1,…,7,0; out alternates 1,0,1,0 lagging cur_sel by one cycle.
  - wrap pulses once every 8 cycles.
- Auto, DWELL=3, N=6: each cur_sel value is held for 3 cycles; the pointer wraps 5→0 with wrap=1; the full period is 18 cycles.
- Out of range, N=6, manual sel=3'd7 → sel_err=1 for one cycle, cur_sel unchanged, then out=0 for one cycle.
- Auto scan with en=0 for 4 cycles at cur_sel=2: the pointer stays at 2 and out keeps tracking live in[2]. After en=1 the pointer resumes at 3 after DWELL cycles. An async rst mid-scan forces cur_sel=0 without waiting for a clock edge.
